// File: rtl/kernel_2mm_launcher_if.sv
// Launch-command, kernel ap_ctrl_hs and completion channels between the launcher and its environment.
interface kernel_2mm_launcher_if;
  localparam int unsigned ARG_W = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 32;

  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ARG_W-1:0] cmd_alpha;
  logic [ARG_W-1:0] cmd_beta;
  logic [TAG_W-1:0] cmd_tag;

  // kernel control handshake
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;

  // scalar kernel arguments
  logic [ARG_W-1:0] alpha;
  logic [ARG_W-1:0] beta;

  // completion channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] rsp_cycles;
  logic             rsp_timeout;

  // launcher side
  modport master (
    input  cmd_valid, cmd_alpha, cmd_beta, cmd_tag,
    input  ap_done, ap_idle, ap_ready,
    input  rsp_ready,
    output cmd_ready, ap_start, alpha, beta,
    output rsp_valid, rsp_tag, rsp_cycles, rsp_timeout
  );

  // host / kernel side
  modport slave (
    output cmd_valid, cmd_alpha, cmd_beta, cmd_tag,
    output ap_done, ap_idle, ap_ready,
    output rsp_ready,
    input  cmd_ready, ap_start, alpha, beta,
    input  rsp_valid, rsp_tag, rsp_cycles, rsp_timeout
  );
endinterface

// File: rtl/kernel_2mm_launcher.sv
// Launches one 2mm kernel run per accepted command, times it, and reports completion or timeout.
module kernel_2mm_launcher #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  kernel_2mm_launcher_if.master bus,
  output logic                  busy,
  output logic [15:0]           run_count
);
  localparam int unsigned ARG_W = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned RUN_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ARG_W-1:0]   r_alpha;
  logic [ARG_W-1:0]   r_beta;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_cnt;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [CNT_W-1:0]   r_rsp_cycles;
  logic               r_rsp_timeout;
  logic               r_rsp_valid;
  logic               r_ap_start;
  logic               r_busy;
  logic [RUN_W-1:0]   r_run_count;

  logic               w_accept;
  logic               w_active;
  logic               w_finish;
  logic               w_finish_to;
  logic               w_rsp_hs;
  logic               w_timeout_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer decode; done takes priority over the timeout on the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_finish      = 1'b0;
    w_finish_to   = 1'b0;
    w_rsp_hs      = 1'b0;
    w_active      = (r_state == S_START) || (r_state == S_RUN);
    w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    w_timeout_hit = (r_cnt == CNT_LAST);
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && bus.ap_idle) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (bus.ap_done) begin
          w_finish    = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout_hit) begin
          w_finish    = 1'b1;
          w_finish_to = 1'b1;
          w_state_nxt = S_RESP;
        end else if (bus.ap_ready) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.ap_done) begin
          w_finish    = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout_hit) begin
          w_finish    = 1'b1;
          w_finish_to = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, run-cycle counter, response capture and completed-run counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alpha       <= '0;
      r_beta        <= '0;
      r_tag         <= '0;
      r_cnt         <= '0;
      r_rsp_tag     <= '0;
      r_rsp_cycles  <= '0;
      r_rsp_timeout <= 1'b0;
      r_run_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alpha <= bus.cmd_alpha;
        r_beta  <= bus.cmd_beta;
        r_tag   <= bus.cmd_tag;
        r_cnt   <= '0;
      end else if (w_active) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_finish) begin
        r_rsp_tag     <= r_tag;
        r_rsp_cycles  <= w_cnt_inc;
        r_rsp_timeout <= w_finish_to;
      end
      if (w_rsp_hs && !r_rsp_timeout) begin
        r_run_count <= r_run_count + RUN_W'(1);
      end
    end
  end

  // Registered status outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ap_start  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ap_start  <= (w_state_nxt == S_START);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // cmd_ready follows ap_idle in IDLE so acceptance happens on the first idle cycle
  assign bus.cmd_ready   = (r_state == S_IDLE) && bus.ap_idle;
  assign bus.ap_start    = r_ap_start;
  assign bus.alpha       = r_alpha;
  assign bus.beta        = r_beta;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_tag     = r_rsp_tag;
  assign bus.rsp_cycles  = r_rsp_cycles;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign busy            = r_busy;
  assign run_count       = r_run_count;

endmodule

// File: tb/tb_kernel_2mm_launcher.sv
// Directed, table-driven bench for kernel_2mm_launcher (TIMEOUT_CYCLES = 20).
module tb_kernel_2mm_launcher;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] run_count;

  int n_checks = 0;
  int n_fail   = 0;

  kernel_2mm_launcher_if bus();

  kernel_2mm_launcher #(.TIMEOUT_CYCLES(32'd20)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .run_count (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alpha;
    logic [31:0] beta;
    logic [3:0]  tag;
    int          rdy_at;      // START/RUN cycle with ap_ready=1 (0 = never)
    int          done_at;     // START/RUN cycle with ap_done=1 (0 = never)
    int          hold;        // extra cycles rsp_ready held low
    int          idle_wait;   // cycles ap_idle=0 while cmd_valid=1 (late ap_done pulsed)
    logic [31:0] exp_cycles;
    logic        exp_to;
    int          exp_starts;  // cycles ap_start observed high
    logic [15:0] exp_runs;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    int          starts;
    logic        ab_ok;
    logic        hold_ok;
    logic [3:0]  tg;
    logic [31:0] cy;
    logic        to;
    bus.cmd_valid = 1'b1;
    bus.cmd_alpha = v.alpha;
    bus.cmd_beta  = v.beta;
    bus.cmd_tag   = v.tag;
    bus.ap_idle   = 1'b0;
    bus.ap_done   = (v.idle_wait > 0);
    for (int k = 0; k < v.idle_wait; k++) begin
      #1;
      check($sformatf("v%0d_gate_ready", idx), 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_gate_busy", idx), 32'(busy), 32'd0);
    end
    bus.ap_done = 1'b0;
    bus.ap_idle = 1'b1;
    #1;
    check($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_alpha = ~v.alpha;
    bus.cmd_beta  = ~v.beta;
    bus.cmd_tag   = ~v.tag;
    check($sformatf("v%0d_start_rise", idx), 32'(bus.ap_start), 32'd1);
    n      = 0;
    starts = 0;
    ab_ok  = 1'b1;
    while (!bus.rsp_valid && n < 60) begin
      n++;
      if (bus.ap_start) starts++;
      if (bus.alpha !== v.alpha || bus.beta !== v.beta || bus.cmd_ready !== 1'b0 || busy !== 1'b1)
        ab_ok = 1'b0;
      bus.ap_ready = (n == v.rdy_at);
      bus.ap_done  = (n == v.done_at);
      @(negedge clk);
    end
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b0;
    check($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
    check($sformatf("v%0d_args_stable", idx), 32'(ab_ok), 32'd1);
    check($sformatf("v%0d_starts", idx), 32'(starts), 32'(v.exp_starts));
    check($sformatf("v%0d_cycles", idx), bus.rsp_cycles, v.exp_cycles);
    check($sformatf("v%0d_timeout", idx), 32'(bus.rsp_timeout), 32'(v.exp_to));
    check($sformatf("v%0d_tag", idx), 32'(bus.rsp_tag), 32'(v.tag));
    tg = bus.rsp_tag;
    cy = bus.rsp_cycles;
    to = bus.rsp_timeout;
    hold_ok = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      bus.ap_done = 1'b1;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== tg || bus.rsp_cycles !== cy ||
          bus.rsp_timeout !== to || bus.cmd_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    bus.ap_done = 1'b0;
    if (v.hold > 0) check($sformatf("v%0d_bp_stable", idx), 32'(hold_ok), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_idle_rsp_valid", idx), 32'(bus.rsp_valid), 32'd0);
    check($sformatf("v%0d_run_count", idx), 32'(run_count), 32'(v.exp_runs));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ap_start"},    32'(bus.ap_start),    32'd0);
    check({pfx, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    check({pfx, "_rsp_tag"},     32'(bus.rsp_tag),     32'd0);
    check({pfx, "_rsp_cycles"},  bus.rsp_cycles,       32'd0);
    check({pfx, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({pfx, "_alpha"},       bus.alpha,            32'd0);
    check({pfx, "_beta"},        bus.beta,             32'd0);
    check({pfx, "_run_count"},   32'(run_count),       32'd0);
    check({pfx, "_busy"},        32'(busy),            32'd0);
  endtask

  initial begin
    //               alpha          beta           tag   rdy done hold iw  cycles  to    starts runs
    vecs[0] = '{32'd3,         32'd2,         4'd5,  2,  12,  0,   0, 32'd12, 1'b0,  2, 16'd1};
    vecs[1] = '{32'hAAAA5555,  32'h12345678,  4'd9,  1,   4,  5,   0, 32'd4,  1'b0,  1, 16'd2};
    vecs[2] = '{32'd7,         32'd8,         4'd3,  1,   0,  0,   0, 32'd20, 1'b1,  1, 16'd2};
    vecs[3] = '{32'd1,         32'd1,         4'hF,  1,   1,  0,   8, 32'd1,  1'b0,  1, 16'd3};
    vecs[4] = '{32'd0,         32'hFFFFFFFF,  4'd0,  3,  20,  2,   0, 32'd20, 1'b0,  3, 16'd4};
    vecs[5] = '{32'hDEADBEEF,  32'd0,         4'hA,  0,   0,  0,   3, 32'd20, 1'b1, 20, 16'd4};
    vecs[6] = '{32'd5,         32'd6,         4'd1,  0,   1,  0,   0, 32'd1,  1'b0,  1, 16'd5};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_alpha = '0;
    bus.cmd_beta  = '0;
    bus.cmd_tag   = '0;
    bus.ap_done   = 1'b0;
    bus.ap_idle   = 1'b0;
    bus.ap_ready  = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
    #1;
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Mid-run reset: abort in RUN, no response, then a normal run from a cleared counter
    bus.ap_idle   = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_alpha = 32'd11;
    bus.cmd_beta  = 32'd22;
    bus.cmd_tag   = 4'd6;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.ap_ready  = 1'b1;
    @(negedge clk);
    bus.ap_ready = 1'b0;
    check("mr_in_run_start", 32'(bus.ap_start), 32'd0);
    check("mr_in_run_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_reset");
    bus.ap_done = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        bus.ap_done = 1'b0;
        if (bus.rsp_valid) seen = 1'b1;
      end
      check("mid_reset_no_rsp", 32'(seen), 32'd0);
    end
    run_vec(vecs[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end
endmodule

// File: doc/kernel_2mm_launcher.md
KERNEL_2MM_LAUNCHER -- requirements
Module: kernel_2mm_launcher

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, meaning the run-cycle limit before a timeout is reported.
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst  input  1  the reset, synchronous and active-high.
REQ-004 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_alpha input 32, cmd_beta input 32 and cmd_tag input 4, forming the launch command channel.
REQ-005 The block SHALL have ports ap_start output 1, ap_done input 1, ap_idle input 1 and ap_ready input 1, forming the kernel ap_ctrl_hs handshake.
REQ-006 The block SHALL have ports alpha output 32 and beta output 32, the scalar arguments driven to the kernel.
REQ-007 The block SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_tag output 4, rsp_cycles output 32 and rsp_timeout output 1, forming the completion channel.
REQ-008 The block SHALL have ports busy output 1 (state is not IDLE) and run_count output 16 (completed-run counter).

Function
REQ-009 The block SHALL implement the states IDLE, START, RUN and RESP.
REQ-010 In IDLE, cmd_ready SHALL equal ap_idle, and cmd_ready SHALL be 0 in every other state.
REQ-011 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; on acceptance the block SHALL latch cmd_alpha, cmd_beta and cmd_tag, clear the cycle counter to 0, and enter START.
REQ-012 The alpha and beta outputs SHALL hold the latched values from the cycle after acceptance until the next acceptance.
REQ-013 ap_start SHALL be 1 exactly while the state is START, registered with no combinational path from any input.
REQ-014 In START, when ap_ready is 1 and ap_done is 0, the block SHALL go to RUN; ap_start SHALL therefore drop the cycle after ap_ready is sampled.
REQ-015 In START or RUN, when ap_done is 1, the block SHALL go to RESP with timeout flag 0; ap_done together with ap_ready in START SHALL go directly to RESP.
REQ-016 The cycle counter SHALL increment by 1 on every cycle in START or RUN, and SHALL saturate at 32'hFFFFFFFF.
REQ-017 If the counter equals TIMEOUT_CYCLES-1 while in START or RUN and ap_done is 0, the block SHALL go to RESP with timeout flag 1, and ap_start SHALL drop.
REQ-018 If ap_done and the timeout condition occur on the same cycle, ap_done SHALL win and the timeout flag SHALL be 0.
REQ-019 rsp_cycles SHALL be the counter value including the terminating cycle: a done sampled in the Nth START/RUN cycle SHALL report N.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_tag, rsp_cycles and rsp_timeout SHALL stay stable until rsp_valid and rsp_ready are both 1; the block SHALL then return to IDLE.
REQ-021 run_count SHALL increment by 1 (wrapping modulo 2^16) on each RESP handshake with rsp_timeout equal to 0.
REQ-022 After a timeout, a late ap_done SHALL be ignored, and no new command SHALL be accepted until ap_idle is 1.
REQ-023 ap_done, ap_ready and ap_idle SHALL be ignored in IDLE and RESP.

Reset
REQ-024 While rst is 1 at a clock edge, the block SHALL enter IDLE.
REQ-025 On reset, the block SHALL drive ap_start=0, rsp_valid=0, rsp_tag=0, rsp_cycles=0, rsp_timeout=0, alpha=0, beta=0, run_count=0 and busy=0, and SHALL clear the cycle counter.
REQ-026 Reset asserted mid-run SHALL abort the run and drop ap_start on the next cycle, with no response emitted.

Verification
REQ-027 Normal run: ap_idle=1, cmd alpha=3, beta=2, tag=5; kernel ap_ready on the 2nd START cycle, ap_done 10 cycles later -> ap_start high for 2 cycles; alpha=3 and beta=2 stable; rsp_tag=5, rsp_cycles=12, rsp_timeout=0; run_count=1.
REQ-028 Back-pressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid and all response fields stable for 5 cycles; cmd_ready=0 throughout; IDLE entered the cycle after the handshake.
REQ-029 Timeout: TIMEOUT_CYCLES=20, kernel never asserts ap_done -> rsp_timeout=1 and rsp_cycles=20; run_count unchanged; with ap_idle=0, a command presented with cmd_valid=1 is not accepted until ap_idle=1.
REQ-030 Simultaneous events: ap_ready and ap_done both 1 on the 1st START cycle -> rsp_cycles=1 and RUN is skipped; done coinciding with the timeout cycle -> rsp_timeout=0.
REQ-031 Mid-run reset: rst pulsed 1 cycle in RUN -> all outputs at reset values the next cycle; no rsp_valid; the next command is accepted normally.
REQ-032 Idle gating: cmd_valid=1 while ap_idle=0 for 8 cycles, then ap_idle=1 -> acceptance on the first cycle with ap_idle=1; ap_start rises on the next cycle.
